// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register file write-back path: default widths
// and the requester encoding used by the round-robin arbiter.
package regfile_wb_arbiter_pkg;

    localparam int RF_ADDR_WIDTH = 5;
    localparam int RF_DATA_WIDTH = 32;

    // Requester identity; also the bit position of each requester in grant vectors
    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_LSU = 1'b1
    } req_e;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter. Bit 0 is the ALU path, bit 1 the LSU path.
// On a conflict the requester that was not granted last wins; the pointer
// only moves when a grant is actually issued.
module rr_arbiter2
    import regfile_wb_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    req_e last_grant;

    // Grant the sole requester, or on a conflict the one not served last
    always_comb begin
        grant = req;
        if (req[0] && req[1]) begin
            if (last_grant == REQ_LSU) begin
                grant = 2'b01;
            end else begin
                grant = 2'b10;
            end
        end
    end

    // Remember who was served so the other side wins the next conflict
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= REQ_LSU;
        end else if (|grant) begin
            last_grant <= grant[1] ? REQ_LSU : REQ_ALU;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back controller for the integer register file. Arbitrates ALU and
// LSU results onto the single write port through one registered stage and
// tracks pending destinations in a busy-bit scoreboard for RAW stalls.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int DATA_WIDTH = RF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [ADDR_WIDTH-1:0] alu_rd,
    input  logic [DATA_WIDTH-1:0] alu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    input  logic                  issue_valid,
    input  logic [ADDR_WIDTH-1:0] issue_rd,
    input  logic [ADDR_WIDTH-1:0] rs1,
    input  logic [ADDR_WIDTH-1:0] rs2,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata
);

    localparam int NUM_REGS = 1 << ADDR_WIDTH;

    logic [1:0]            grant;
    logic                  wb_fire;
    logic [ADDR_WIDTH-1:0] wb_rd;
    logic [DATA_WIDTH-1:0] wb_data;
    logic [NUM_REGS-1:0]   busy;
    logic [NUM_REGS-1:0]   busy_next;

    rr_arbiter2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   ({lsu_valid, alu_valid}),
        .grant (grant)
    );

    assign alu_ready = grant[0];
    assign lsu_ready = grant[1];

    // Ready equals grant, so any grant is a completed handshake
    always_comb begin
        wb_fire = |grant;
        wb_rd   = grant[1] ? lsu_rd   : alu_rd;
        wb_data = grant[1] ? lsu_data : alu_data;
    end

    // Register the winning write; x0 targets complete the handshake but never enable the port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_wen   <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_wen <= wb_fire && (wb_rd != '0);
            if (wb_fire) begin
                rf_waddr <= wb_rd;
                rf_wdata <= wb_data;
            end
        end
    end

    // Clear on commit, then set on issue so a newer producer of the same index wins
    always_comb begin
        busy_next = busy;
        if (rf_wen) begin
            busy_next[rf_waddr] = 1'b0;
        end
        if (issue_valid && (issue_rd != '0)) begin
            busy_next[issue_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // Scoreboard register; an in-flight write dropped by reset leaves nothing pending
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    // Hazard query reads the registered vector directly, with no bypass
    always_comb begin
        rs1_busy = busy[rs1];
        rs2_busy = busy[rs2];
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a transaction-level model tracks the
// pending write, scoreboard and fairness pointer, and every cycle's outputs
// are compared against it, alongside hand-computed literal expectations.
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int compared;
    int mismatched;

    // Model state: pending registers, the last-served requester and the write latched last cycle
    bit [31:0]   m_busy;
    bit          m_last_was_lsu;
    bit          m_wen;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;

    regfile_wb_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .lsu_valid   (lsu_valid),
        .lsu_ready   (lsu_ready),
        .lsu_rd      (lsu_rd),
        .lsu_data    (lsu_data),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .rf_wen      (rf_wen),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation ran past 200000 time units, required completion");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Who should be served right now: sole requester, or the one not served last on a conflict
    function automatic bit [1:0] model_grant();
        if (alu_valid && lsu_valid) return m_last_was_lsu ? 2'b01 : 2'b10;
        return {lsu_valid, alu_valid};
    endfunction

    function automatic void model_reset();
        m_busy         = '0;
        m_last_was_lsu = 1'b1;
        m_wen          = 1'b0;
        m_waddr        = '0;
        m_wdata        = '0;
    endfunction

    // Advance the model across one rising edge using the inputs held during the cycle
    function automatic void model_update();
        bit [1:0]  g;
        bit [31:0] nb;
        g  = model_grant();
        nb = m_busy;
        if (m_wen) nb[m_waddr] = 1'b0;
        if (issue_valid && issue_rd != 0) nb[issue_rd] = 1'b1;
        nb[0] = 1'b0;
        m_busy = nb;
        m_wen  = 1'b0;
        if (g != 2'b00) begin
            m_last_was_lsu = g[1];
            m_waddr        = g[1] ? lsu_rd : alu_rd;
            m_wdata        = g[1] ? lsu_data : alu_data;
            m_wen          = (m_waddr != 0);
        end
    endfunction

    // Per-cycle comparison of every output against the model
    task automatic compare_model();
        bit [1:0] g;
        g = model_grant();
        checkOutput("model alu_ready", {31'd0, alu_ready}, {31'd0, g[0]});
        checkOutput("model lsu_ready", {31'd0, lsu_ready}, {31'd0, g[1]});
        checkOutput("model rf_wen", {31'd0, rf_wen}, {31'd0, m_wen});
        checkOutput("model rf_waddr", {27'd0, rf_waddr}, {27'd0, m_waddr});
        checkOutput("model rf_wdata", rf_wdata, m_wdata);
        checkOutput("model rs1_busy", {31'd0, rs1_busy}, {31'd0, m_busy[rs1]});
        checkOutput("model rs2_busy", {31'd0, rs2_busy}, {31'd0, m_busy[rs2]});
    endtask

    // One clock: check at the falling edge, advance the model at the rising edge
    task automatic cycle();
        @(negedge clk);
        compare_model();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic applyStimulus(input logic av, input logic [4:0] ard, input logic [31:0] adata,
                                 input logic lv, input logic [4:0] lrd, input logic [31:0] ldata,
                                 input logic iv, input logic [4:0] ird,
                                 input logic [4:0] r1, input logic [4:0] r2);
        alu_valid   = av;
        alu_rd      = ard;
        alu_data    = adata;
        lsu_valid   = lv;
        lsu_rd      = lrd;
        lsu_data    = ldata;
        issue_valid = iv;
        issue_rd    = ird;
        rs1         = r1;
        rs2         = r2;
        #1;
    endtask

    task automatic do_reset();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        model_update();
        #1;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        model_reset();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Reset then idle
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 5, 31);
        checkOutput("idle rf_wen", {31'd0, rf_wen}, 32'd0);
        checkOutput("idle rs1_busy", {31'd0, rs1_busy}, 32'd0);
        checkOutput("idle rs2_busy", {31'd0, rs2_busy}, 32'd0);
        checkOutput("idle readies", {30'd0, lsu_ready, alu_ready}, 32'd0);
        cycle();

        // ALU only write to x3
        applyStimulus(1, 3, 32'hDEADBEEF, 0, 0, 0, 0, 0, 5, 31);
        checkOutput("alu only ready", {31'd0, alu_ready}, 32'd1);
        cycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 5, 31);
        checkOutput("alu only rf_wen T+1", {31'd0, rf_wen}, 32'd1);
        checkOutput("alu only rf_waddr", {27'd0, rf_waddr}, 32'd3);
        checkOutput("alu only rf_wdata", rf_wdata, 32'hDEADBEEF);
        cycle();
        checkOutput("alu only rf_wen T+2", {31'd0, rf_wen}, 32'd0);
        cycle();

        // Both requesters held for four cycles from a fresh pointer
        do_reset();
        applyStimulus(1, 1, 32'h11, 1, 2, 32'h22, 0, 0, 0, 0);
        checkOutput("rr c0 grant", {30'd0, lsu_ready, alu_ready}, 32'b01);
        cycle();
        checkOutput("rr c1 grant", {30'd0, lsu_ready, alu_ready}, 32'b10);
        checkOutput("rr c1 write", {rf_wen, 2'd0, rf_waddr, rf_wdata[23:0]}, {1'b1, 2'd0, 5'd1, 24'h11});
        cycle();
        checkOutput("rr c2 grant", {30'd0, lsu_ready, alu_ready}, 32'b01);
        checkOutput("rr c2 write", {rf_wen, 2'd0, rf_waddr, rf_wdata[23:0]}, {1'b1, 2'd0, 5'd2, 24'h22});
        cycle();
        checkOutput("rr c3 grant", {30'd0, lsu_ready, alu_ready}, 32'b10);
        cycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle();

        // Issue x7, later an LSU write-back clears it
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
        cycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
        checkOutput("raw busy T+1", {31'd0, rs1_busy}, 32'd1);
        cycle();
        cycle();
        applyStimulus(0, 0, 0, 1, 7, 32'h7777, 0, 0, 7, 0);
        checkOutput("raw lsu grant T+3", {31'd0, lsu_ready}, 32'd1);
        cycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
        checkOutput("raw rf_wen T+4", {31'd0, rf_wen}, 32'd1);
        checkOutput("raw busy T+4", {31'd0, rs1_busy}, 32'd1);
        cycle();
        checkOutput("raw busy T+5", {31'd0, rs1_busy}, 32'd0);
        cycle();

        // Commit of x9 coincides with a new issue of x9; also set x12 for later
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 9, 9, 12);
        cycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 12, 9, 12);
        cycle();
        applyStimulus(1, 9, 32'h99, 0, 0, 0, 0, 0, 9, 12);
        cycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 9, 9, 12);
        checkOutput("conflict rf_wen", {31'd0, rf_wen}, 32'd1);
        cycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 9, 12);
        checkOutput("conflict busy9 kept", {31'd0, rs1_busy}, 32'd1);
        cycle();

        // Commit of x9 alongside issue of x10: both take effect
        applyStimulus(0, 0, 0, 1, 9, 32'h900, 0, 0, 9, 10);
        cycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 10, 9, 10);
        cycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 9, 10);
        checkOutput("diff idx busy9 cleared", {31'd0, rs1_busy}, 32'd0);
        checkOutput("diff idx busy10 set", {31'd0, rs2_busy}, 32'd1);
        cycle();

        // Write-back to x0: handshake completes, nothing written or cleared
        applyStimulus(1, 0, 32'h55, 0, 0, 0, 0, 0, 0, 12);
        checkOutput("x0 wb ready", {31'd0, alu_ready}, 32'd1);
        cycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 12);
        checkOutput("x0 wb rf_wen", {31'd0, rf_wen}, 32'd0);
        checkOutput("x0 wb busy12 kept", {31'd0, rs2_busy}, 32'd1);
        cycle();

        // Issue to x0 leaves x0 clear
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0, 12);
        cycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 12);
        checkOutput("x0 issue busy0", {31'd0, rs1_busy}, 32'd0);
        cycle();

        // Async reset in the cycle after a handshake drops the in-flight write
        applyStimulus(1, 5, 32'hABCD, 0, 0, 0, 1, 4, 4, 12);
        cycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 4, 12);
        checkOutput("pre reset rf_wen", {31'd0, rf_wen}, 32'd1);
        checkOutput("pre reset busy4", {31'd0, rs1_busy}, 32'd1);
        rst_n = 1'b0;
        model_reset();
        #1;
        checkOutput("async reset rf_wen", {31'd0, rf_wen}, 32'd0);
        checkOutput("async reset rf_waddr", {27'd0, rf_waddr}, 32'd0);
        checkOutput("async reset busy4", {31'd0, rs1_busy}, 32'd0);
        checkOutput("async reset busy12", {31'd0, rs2_busy}, 32'd0);
        for (int i = 1; i < 32; i++) begin
            rs1 = i[4:0];
            #1;
            checkOutput("async reset busy sweep", {31'd0, rs1_busy}, 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        model_update();
        #1;
        cycle();
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Write-back controller for the integer register file (32 x 32b, single write port, x0 hard-wired to zero).
- Arbitrates between two write-back requesters, the EXU ALU path and the LSU load path, using round-robin valid/ready handshakes.
- Drives the register file write port through one registered stage.
- Keeps a busy-bit scoreboard of destination registers so the issue stage can stall on RAW hazards.

Parameters:
- ADDR_WIDTH, 5, register index width; register count is 2**ADDR_WIDTH.
- DATA_WIDTH, 32, register data width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- alu_valid  in  1  ALU write-back request.
- alu_ready  out  1  ALU request granted this cycle.
- alu_rd  in  ADDR_WIDTH  ALU destination register.
- alu_data  in  DATA_WIDTH  ALU result.
- lsu_valid  in  1  LSU write-back request.
- lsu_ready  out  1  LSU request granted this cycle.
- lsu_rd  in  ADDR_WIDTH  LSU destination register.
- lsu_data  in  DATA_WIDTH  load data.
- issue_valid  in  1  an instruction writing issue_rd issues this cycle.
- issue_rd  in  ADDR_WIDTH  destination of the issuing instruction.
- rs1  in  ADDR_WIDTH  source 1 index for the hazard query.
- rs2  in  ADDR_WIDTH  source 2 index for the hazard query.
- rs1_busy  out  1  rs1 has a pending uncommitted write.
- rs2_busy  out  1  rs2 has a pending uncommitted write.
- rf_wen  out  1  register file write enable.
- rf_waddr  out  ADDR_WIDTH  register file write address.
- rf_wdata  out  DATA_WIDTH  register file write data.

Behaviour:
- Reset (async assert, sync release):
  - rf_wen=0, rf_waddr=0, rf_wdata=0.
  - busy[all]=0.
  - Round-robin pointer last_grant=LSU, so the ALU wins the first conflict.
  - A write that was accepted but not yet committed is dropped.
- Arbitration (combinational):
  - Only one valid: that requester is granted.
  - Both valid: the requester not equal to last_grant is granted.
  - Neither valid: no grant.
  - alu_ready/lsu_ready equal the grant; at most one is high in any cycle.
  - Handshake = valid & ready. On a handshake, last_grant updates to the granted requester at the next edge.
  - A requester must hold valid, rd and data stable until its ready is seen.
  - The losing requester is granted on the following cycle. Neither requester waits more than 1 cycle.
- Write stage:
  - A handshake in cycle T registers rf_waddr/rf_wdata at edge T+1.
  - rf_wen is high during cycle T+1 only if rd != 0, so the register file commits at edge T+2.
  - With no handshake in T, rf_wen=0 in T+1 and rf_waddr/rf_wdata hold their previous values.
  - Throughput is one write per cycle, back-to-back.
- Scoreboard:
  - busy[ADDR] is a register vector.
  - Set: issue_valid & issue_rd != 0 sets busy[issue_rd] at the next edge.
  - Clear: rf_wen high clears busy[rf_waddr] at the same edge the register file commits. When busy reads 0, the register file already holds the new value.
  - Set and clear of the same index at the same edge: set wins (a newer producer exists).
  - Set and clear of different indices at the same edge: both take effect.
  - busy[0] is always 0.
  - Handshakes to x0 never clear any bit.
- Hazard query:
  - rs1_busy = busy[rs1] and rs2_busy = busy[rs2], combinational from the register vector.
  - No bypass.
  - rs=0 always reads 0.
- No check that a write-back matches an outstanding busy bit. The issue stage guarantees one write-back per issued rd.

Decomposition:
- Shared package:
  - requester encoding constants REQ_ALU=0, REQ_LSU=1.
  - ADDR_WIDTH and DATA_WIDTH defaults, shared with the register file.
- One natural sub-module: rr_arbiter2, a 2-way round-robin grant with a pointer register.
- The scoreboard and write stage stay inline.

Test Plan:
- Reset then idle: rf_wen=0, rs1_busy=0 and rs2_busy=0 for rs1=5 and rs2=31, both readies 0.
- ALU only, alu_rd=3, alu_data=0xDEADBEEF in cycle T:
  - alu_ready=1 in T.
  - rf_wen=1, rf_waddr=3, rf_wdata=0xDEADBEEF in T+1.
  - rf_wen=0 in T+2.
- Both valid held 4 cycles, alu_rd=1/data=0x11 and lsu_rd=2/data=0x22:
  - Grants are ALU, LSU in consecutive cycles.
  - rf writes are (1,0x11) then (2,0x22), back-to-back.
- Issue rd=7 at T:
  - rs1_busy=1 for rs1=7 from T+1.
  - LSU write-back rd=7 is granted at T+3, rf_wen at T+4, and rs1_busy=0 from T+5.
- Same-edge conflict: rf_wen commits rd=9 while issue_valid with issue_rd=9 in the same cycle -> busy[9] stays 1.
- Corner cases:
  - Write-back with rd=0: handshake completes, rf_wen stays 0, busy unchanged.
  - Issue with rd=0: busy unchanged.
  - rst_n low in the cycle after a handshake: rf_wen=0 immediately (async) and all busy bits are 0.
